// File: rtl/fsqrt_sched.sv
// Round-robin scheduler sharing one fully pipelined fsqrt unit between NREQ requesters.
// Define FSQRT_SCHED_STATS_EN to add the issue_cnt / conflict_cnt statistics ports.
module fsqrt_sched #(
  parameter  int NREQ = 2,
  parameter  int LAT  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_y,
  output logic [31:0]          sq_x,
  input  logic [31:0]          sq_y,
  output logic                 busy
`ifdef FSQRT_SCHED_STATS_EN
  ,
  output logic [31:0]          issue_cnt,
  output logic [31:0]          conflict_cnt
`endif
);

  // Stage 0 aligns with sq_x; the unit samples sq_x one edge later, so the tag
  // must travel LAT+1 more stages to meet sq_y.
  localparam int NSTG = LAT + 2;

  logic [IDW-1:0]  rr_ptr_r;
  logic [31:0]     sq_x_r;
  logic [NSTG-1:0] tag_vld_r;
  logic [IDW-1:0]  tag_id_r [NSTG];

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW-1:0]  next_ptr_s;
  logic [31:0]     issue_x_s;
  logic            found_s;
  logic            issue_s;

  // Rotating priority search: first pass from rr_ptr upward, second pass wraps to 0.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && !rstn && req_valid[i] && (i >= int'(rr_ptr_r))) begin
        grant_s[i] = 1'b1;
        grant_id_s = IDW'(i);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && !rstn && req_valid[i]) begin
        grant_s[i] = 1'b1;
        grant_id_s = IDW'(i);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_comb begin
    next_ptr_s = '0;
    if (grant_id_s == IDW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_s + IDW'(1);
    end
  end

  // One-hot operand mux.
  always_comb begin
    issue_x_s = 32'h0000_0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        issue_x_s = issue_x_s | req_x[32*i +: 32];
      end else begin
        issue_x_s = issue_x_s;
      end
    end
  end

  assign issue_s   = |grant_s;
  assign req_ready = grant_s;

  // Operand register, round-robin pointer and tag shift register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rr_ptr_r  <= '0;
      sq_x_r    <= 32'h0000_0000;
      tag_vld_r <= '0;
      for (int k = 0; k < NSTG; k++) begin
        tag_id_r[k] <= '0;
      end
    end else begin
      if (issue_s) begin
        sq_x_r   <= issue_x_s;
        rr_ptr_r <= next_ptr_s;
      end
      tag_vld_r   <= {tag_vld_r[NSTG-2:0], issue_s};
      tag_id_r[0] <= grant_id_s;
      for (int k = 1; k < NSTG; k++) begin
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Decode the retiring tag into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_r[NSTG-1]) begin
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid[i] = (tag_id_r[NSTG-1] == IDW'(i));
      end
    end else begin
      rsp_valid = '0;
    end
  end

  assign rsp_y = sq_y;
  assign sq_x  = sq_x_r;
  assign busy  = |tag_vld_r;

`ifdef FSQRT_SCHED_STATS_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] conflict_cnt_r;
  logic        conflict_s;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign conflict_s = ((req_valid & (req_valid - NREQ'(1))) != '0);

  // Free-running statistics counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      issue_cnt_r    <= 32'h0000_0000;
      conflict_cnt_r <= 32'h0000_0000;
    end else begin
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + 32'h0000_0001;
      end
      if (conflict_s) begin
        conflict_cnt_r <= conflict_cnt_r + 32'h0000_0001;
      end
    end
  end

  assign issue_cnt    = issue_cnt_r;
  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
